// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, one-hot ALU operation
// bit positions, instruction field positions and decoder state/record types.
package cpu_isa_pkg;

  localparam int ISA_DATA_W    = 16;
  localparam int ISA_OP_W      = 13;
  localparam int ISA_REG_AW    = 3;
  localparam int ISA_ILL_CNT_W = 8;

  localparam logic [4:0] OPC_NOP = 5'b00000;
  localparam logic [4:0] OPC_NOT = 5'b00001;
  localparam logic [4:0] OPC_INC = 5'b00010;
  localparam logic [4:0] OPC_DEC = 5'b00011;
  localparam logic [4:0] OPC_OUT = 5'b00100;
  localparam logic [4:0] OPC_IN  = 5'b00101;
  localparam logic [4:0] OPC_MOV = 5'b01000;
  localparam logic [4:0] OPC_ADD = 5'b01001;
  localparam logic [4:0] OPC_SUB = 5'b01010;
  localparam logic [4:0] OPC_AND = 5'b01011;
  localparam logic [4:0] OPC_OR  = 5'b01100;
  localparam logic [4:0] OPC_SHL = 5'b01101;
  localparam logic [4:0] OPC_SHR = 5'b01110;
  localparam logic [4:0] OPC_LDM = 5'b10000;

  localparam int OP_OUT = 12;
  localparam int OP_IN  = 11;
  localparam int OP_NOP = 10;
  localparam int OP_NOT = 9;
  localparam int OP_MOV = 8;
  localparam int OP_ADD = 7;
  localparam int OP_SUB = 6;
  localparam int OP_AND = 5;
  localparam int OP_OR  = 4;
  localparam int OP_SHL = 3;
  localparam int OP_SHR = 2;
  localparam int OP_INC = 1;
  localparam int OP_DEC = 0;

  localparam logic [ISA_OP_W-1:0] NOP_ONEHOT = 13'h0400;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 11;
  localparam int RSRC_MSB  = 10;
  localparam int RSRC_LSB  = 8;
  localparam int RDST_MSB  = 7;
  localparam int RDST_LSB  = 5;
  localparam int SHAMT_MSB = 4;
  localparam int SHAMT_LSB = 1;

  typedef enum logic {
    ST_DECODE   = 1'b0,
    ST_WAIT_IMM = 1'b1
  } dec_state_e;

  function automatic logic [ISA_OP_W-1:0] onehotOp(input int idx);
    return ISA_OP_W'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_op_lut.sv
// Combinational opcode table: maps a 5-bit opcode to its one-hot ALU operation
// and the per-opcode control flags used by the decoder.
module alu_op_lut
  import cpu_isa_pkg::*;
(
  input  logic [4:0]          opcode_i,
  output logic [ISA_OP_W-1:0] aluOperation_o,
  output logic                regWrite_o,
  output logic                usesShamt_o,
  output logic                isLdm_o,
  output logic                illegal_o
);

  // Undefined opcodes fall through to NOP so the one-hot bus is never empty.
  always_comb begin
    aluOperation_o = NOP_ONEHOT;
    regWrite_o     = 1'b0;
    usesShamt_o    = 1'b0;
    isLdm_o        = 1'b0;
    illegal_o      = 1'b0;
    case (opcode_i)
      OPC_NOP: aluOperation_o = NOP_ONEHOT;
      OPC_NOT: begin aluOperation_o = onehotOp(OP_NOT); regWrite_o = 1'b1; end
      OPC_INC: begin aluOperation_o = onehotOp(OP_INC); regWrite_o = 1'b1; end
      OPC_DEC: begin aluOperation_o = onehotOp(OP_DEC); regWrite_o = 1'b1; end
      OPC_OUT: aluOperation_o = onehotOp(OP_OUT);
      OPC_IN:  begin aluOperation_o = onehotOp(OP_IN);  regWrite_o = 1'b1; end
      OPC_MOV: begin aluOperation_o = onehotOp(OP_MOV); regWrite_o = 1'b1; end
      OPC_ADD: begin aluOperation_o = onehotOp(OP_ADD); regWrite_o = 1'b1; end
      OPC_SUB: begin aluOperation_o = onehotOp(OP_SUB); regWrite_o = 1'b1; end
      OPC_AND: begin aluOperation_o = onehotOp(OP_AND); regWrite_o = 1'b1; end
      OPC_OR:  begin aluOperation_o = onehotOp(OP_OR);  regWrite_o = 1'b1; end
      OPC_SHL: begin
        aluOperation_o = onehotOp(OP_SHL);
        regWrite_o     = 1'b1;
        usesShamt_o    = 1'b1;
      end
      OPC_SHR: begin
        aluOperation_o = onehotOp(OP_SHR);
        regWrite_o     = 1'b1;
        usesShamt_o    = 1'b1;
      end
      OPC_LDM: begin
        aluOperation_o = onehotOp(OP_MOV);
        regWrite_o     = 1'b1;
        isLdm_o        = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Decode stage: turns fetched words into registered ID/EX controls, sequences
// the two-word LDM, honours stall/flush and counts illegal opcodes.
module alu_op_decoder
  import cpu_isa_pkg::*;
#(
  parameter int DATA_W    = ISA_DATA_W,
  parameter int OP_W      = ISA_OP_W,
  parameter int REG_AW    = ISA_REG_AW,
  parameter int ILL_CNT_W = ISA_ILL_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [DATA_W-1:0]    instr,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [OP_W-1:0]      ex_alu_operation,
  output logic [3:0]           ex_shamt,
  output logic [REG_AW-1:0]    ex_rsrc,
  output logic [REG_AW-1:0]    ex_rdst,
  output logic [DATA_W-1:0]    ex_imm,
  output logic                 ex_imm_sel,
  output logic                 ex_reg_write,
  output logic                 ex_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  dec_state_e           state_q;
  logic [REG_AW-1:0]    rdstLatch_q;
  logic                 exValid_q;
  logic [OP_W-1:0]      exOp_q;
  logic [3:0]           exShamt_q;
  logic [REG_AW-1:0]    exRsrc_q;
  logic [REG_AW-1:0]    exRdst_q;
  logic [DATA_W-1:0]    exImm_q;
  logic                 exImmSel_q;
  logic                 exRegWrite_q;
  logic                 exIllegal_q;
  logic [ILL_CNT_W-1:0] illCnt_q;
  logic [ILL_CNT_W-1:0] illCnt_d;

  logic [4:0]        opcode;
  logic [REG_AW-1:0] fieldRsrc;
  logic [REG_AW-1:0] fieldRdst;
  logic [3:0]        fieldShamt;
  logic [OP_W-1:0]   lutOp;
  logic              lutRegWrite;
  logic              lutUsesShamt;
  logic              lutIsLdm;
  logic              lutIllegal;

  assign opcode     = instr[OPC_MSB:OPC_LSB];
  assign fieldRsrc  = instr[RSRC_MSB:RSRC_LSB];
  assign fieldRdst  = instr[RDST_MSB:RDST_LSB];
  assign fieldShamt = instr[SHAMT_MSB:SHAMT_LSB];

  alu_op_lut uLut (
    .opcode_i       (opcode),
    .aluOperation_o (lutOp),
    .regWrite_o     (lutRegWrite),
    .usesShamt_o    (lutUsesShamt),
    .isLdm_o        (lutIsLdm),
    .illegal_o      (lutIllegal)
  );

  assign illCnt_d = (illCnt_q == '1) ? illCnt_q : illCnt_q + ILL_CNT_W'(1);

  // Flush outranks stall; a stalled cycle leaves every register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DECODE;
      rdstLatch_q  <= '0;
      exValid_q    <= 1'b0;
      exOp_q       <= NOP_ONEHOT;
      exShamt_q    <= '0;
      exRsrc_q     <= '0;
      exRdst_q     <= '0;
      exImm_q      <= '0;
      exImmSel_q   <= 1'b0;
      exRegWrite_q <= 1'b0;
      exIllegal_q  <= 1'b0;
      illCnt_q     <= '0;
    end else if (flush) begin
      state_q      <= ST_DECODE;
      exValid_q    <= 1'b0;
      exOp_q       <= NOP_ONEHOT;
      exShamt_q    <= '0;
      exRsrc_q     <= '0;
      exRdst_q     <= '0;
      exImm_q      <= '0;
      exImmSel_q   <= 1'b0;
      exRegWrite_q <= 1'b0;
      exIllegal_q  <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        ST_DECODE: begin
          if (instr_valid && !lutIsLdm) begin
            exValid_q    <= 1'b1;
            exOp_q       <= lutOp;
            exShamt_q    <= lutUsesShamt ? fieldShamt : 4'd0;
            exRsrc_q     <= fieldRsrc;
            exRdst_q     <= fieldRdst;
            exImm_q      <= '0;
            exImmSel_q   <= 1'b0;
            exRegWrite_q <= lutRegWrite;
            exIllegal_q  <= lutIllegal;
            if (lutIllegal) begin
              illCnt_q <= illCnt_d;
            end
          end else begin
            // LDM opcode word only arms the sequencer; EX sees a bubble.
            if (instr_valid) begin
              rdstLatch_q <= fieldRdst;
              state_q     <= ST_WAIT_IMM;
            end
            exValid_q    <= 1'b0;
            exOp_q       <= NOP_ONEHOT;
            exShamt_q    <= '0;
            exRsrc_q     <= '0;
            exRdst_q     <= '0;
            exImm_q      <= '0;
            exImmSel_q   <= 1'b0;
            exRegWrite_q <= 1'b0;
            exIllegal_q  <= 1'b0;
          end
        end
        ST_WAIT_IMM: begin
          if (instr_valid) begin
            state_q      <= ST_DECODE;
            exValid_q    <= 1'b1;
            exOp_q       <= onehotOp(OP_MOV);
            exShamt_q    <= '0;
            exRsrc_q     <= '0;
            exRdst_q     <= rdstLatch_q;
            exImm_q      <= instr;
            exImmSel_q   <= 1'b1;
            exRegWrite_q <= 1'b1;
            exIllegal_q  <= 1'b0;
          end else begin
            exValid_q    <= 1'b0;
            exOp_q       <= NOP_ONEHOT;
            exShamt_q    <= '0;
            exRsrc_q     <= '0;
            exRdst_q     <= '0;
            exImm_q      <= '0;
            exImmSel_q   <= 1'b0;
            exRegWrite_q <= 1'b0;
            exIllegal_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ex_valid         = exValid_q;
  assign ex_alu_operation = exOp_q;
  assign ex_shamt         = exShamt_q;
  assign ex_rsrc          = exRsrc_q;
  assign ex_rdst          = exRdst_q;
  assign ex_imm           = exImm_q;
  assign ex_imm_sel       = exImmSel_q;
  assign ex_reg_write     = exRegWrite_q;
  assign ex_illegal       = exIllegal_q;
  assign ill_count        = illCnt_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboarded bench for alu_op_decoder: random and directed words are checked
// against an instruction-level reference model of the decode stage.
module tb_alu_op_decoder;

  typedef struct packed {
    logic        valid;
    logic [12:0] op;
    logic [3:0]  shamt;
    logic [2:0]  rsrc;
    logic [2:0]  rdst;
    logic [15:0] imm;
    logic        immSel;
    logic        regWrite;
    logic        illegal;
    logic [7:0]  illCnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [12:0] ex_alu_operation;
  logic [3:0]  ex_shamt;
  logic [2:0]  ex_rsrc;
  logic [2:0]  ex_rdst;
  logic [15:0] ex_imm;
  logic        ex_imm_sel;
  logic        ex_reg_write;
  logic        ex_illegal;
  logic [7:0]  ill_count;

  int   checkCount = 0;
  int   failCount  = 0;
  exp_t expQ[$];

  int   opTable[32];
  exp_t modelExp;
  logic modelPending;
  logic [2:0] modelRdst;

  alu_op_decoder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .stall            (stall),
    .flush            (flush),
    .ex_valid         (ex_valid),
    .ex_alu_operation (ex_alu_operation),
    .ex_shamt         (ex_shamt),
    .ex_rsrc          (ex_rsrc),
    .ex_rdst          (ex_rdst),
    .ex_imm           (ex_imm),
    .ex_imm_sel       (ex_imm_sel),
    .ex_reg_write     (ex_reg_write),
    .ex_illegal       (ex_illegal),
    .ill_count        (ill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t bubbleOf(input logic [7:0] cnt);
    exp_t e;
    e = '0;
    e.op = 13'h0400;
    e.illCnt = cnt;
    return e;
  endfunction

  // Reference model: one call per clock, mirrors instruction-level semantics.
  task automatic modelStep(input logic v, input logic [15:0] w, input logic st, input logic fl);
    int idx;
    logic [4:0] opc;
    opc = w[15:11];
    if (fl) begin
      modelPending = 1'b0;
      modelExp = bubbleOf(modelExp.illCnt);
    end else if (st) begin
      modelExp = modelExp;
    end else if (modelPending) begin
      if (v) begin
        modelExp = bubbleOf(modelExp.illCnt);
        modelExp.valid = 1'b1;
        modelExp.op = 13'h0100;
        modelExp.rdst = modelRdst;
        modelExp.imm = w;
        modelExp.immSel = 1'b1;
        modelExp.regWrite = 1'b1;
        modelPending = 1'b0;
      end else begin
        modelExp = bubbleOf(modelExp.illCnt);
      end
    end else if (!v) begin
      modelExp = bubbleOf(modelExp.illCnt);
    end else if (opc == 5'b10000) begin
      modelPending = 1'b1;
      modelRdst = w[7:5];
      modelExp = bubbleOf(modelExp.illCnt);
    end else begin
      idx = opTable[opc];
      modelExp = bubbleOf(modelExp.illCnt);
      modelExp.valid = 1'b1;
      modelExp.rsrc = w[10:8];
      modelExp.rdst = w[7:5];
      if (idx < 0) begin
        modelExp.illegal = 1'b1;
        if (modelExp.illCnt != 8'hFF) modelExp.illCnt = modelExp.illCnt + 8'd1;
      end else begin
        modelExp.op = 13'(1) << idx;
        modelExp.regWrite = (idx != 10) && (idx != 12);
        if (idx == 3 || idx == 2) modelExp.shamt = w[4:1];
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] w, input logic st, input logic fl);
    @(negedge clk);
    instr_valid = v;
    instr = w;
    stall = st;
    flush = fl;
    modelStep(v, w, st, fl);
    expQ.push_back(modelExp);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("resetOp", 64'(ex_alu_operation), 64'h0400);
    checkOutput("resetValidCnt", 64'({ex_valid, ill_count}), 64'h0);
    modelPending = 1'b0;
    modelExp = bubbleOf(8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle carrying a scheduled expectation is compared.
  initial begin
    exp_t act;
    exp_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expQ.size() > 0) begin
        exp = expQ.pop_front();
        act = {ex_valid, ex_alu_operation, ex_shamt, ex_rsrc, ex_rdst, ex_imm,
               ex_imm_sel, ex_reg_write, ex_illegal, ill_count};
        checkOutput("exOut", 64'(act), 64'(exp));
        checkOutput("onehot", 64'($onehot(ex_alu_operation)), 64'd1);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] legalOpc[14];
    logic [4:0] opc;
    logic [15:0] w;
    int drain;
    legalOpc = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b01000,
                 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b10000};
    for (int i = 0; i < 32; i++) opTable[i] = -1;
    opTable[5'b00000] = 10; opTable[5'b00001] = 9;  opTable[5'b00010] = 1;
    opTable[5'b00011] = 0;  opTable[5'b00100] = 12; opTable[5'b00101] = 11;
    opTable[5'b01000] = 8;  opTable[5'b01001] = 7;  opTable[5'b01010] = 6;
    opTable[5'b01011] = 5;  opTable[5'b01100] = 4;  opTable[5'b01101] = 3;
    opTable[5'b01110] = 2;

    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    stall = 1'b0;
    flush = 1'b0;
    modelPending = 1'b0;
    modelRdst = '0;
    modelExp = bubbleOf(8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 16'h4AA0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("addOp", 64'(ex_alu_operation), 64'h0080);
    checkOutput("addFields", 64'({ex_rsrc, ex_rdst, ex_reg_write}), 64'({3'd2, 3'd5, 1'b1}));

    applyStimulus(1'b1, 16'h6806, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("shlOpShamt", 64'({ex_alu_operation, ex_shamt}), 64'({13'h0008, 4'd3}));
    applyStimulus(1'b1, 16'h7120, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h4A1E, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h8060, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("ldmResult", 64'({ex_alu_operation, ex_imm, ex_imm_sel, ex_rdst}),
                64'({13'h0100, 16'hBEEF, 1'b1, 3'd3}));

    applyStimulus(1'b1, 16'h8060, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    applyStimulus(1'b1, 16'h8060, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h4AA0, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h4AA0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("afterFlushAdd", 64'({ex_alu_operation, ex_imm_sel}), 64'({13'h0080, 1'b0}));

    applyStimulus(1'b1, 16'h8060, 1'b0, 1'b0);
    @(posedge clk);
    doReset();
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 15) opc = 5'($urandom_range(31));
      else opc = legalOpc[$urandom_range(13)];
      w = {opc, 11'($urandom)};
      applyStimulus($urandom_range(99) < 80, w, $urandom_range(99) < 10, $urandom_range(99) < 5);
    end

    @(posedge clk);
    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, {5'b11111, 11'($urandom)}, 1'b0, 1'b0);
    end
    @(posedge clk); #2;
    checkOutput("illSaturate", 64'({ill_count, ex_illegal, ex_valid, ex_alu_operation}),
                64'({8'hFF, 1'b1, 1'b1, 13'h0400}));

    @(negedge clk);
    instr_valid = 1'b0;
    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
